// File: rtl/aes_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_stream_if                                                 |
// | Brief    : DW-bit valid/ready front end for the AES core: key/text        |
// |            buffers, command handshake, start pulse, result streaming.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module aes_stream_if #(
   parameter int DW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic [DW-1:0]  din,
   input  logic           din_valid,
   input  logic           din_key,
   output logic           din_ready,
   input  logic           cmd_valid,
   input  logic           cmd_dec,
   output logic           cmd_ready,
   output logic [127:0]   core_key,
   output logic [127:0]   core_text,
   output logic           core_start,
   output logic           core_dec,
   input  logic           core_done,
   input  logic [127:0]   core_result,
   output logic [DW-1:0]  dout,
   output logic           dout_valid,
   input  logic           dout_ready,
   output logic           key_full,
   output logic           text_full,
   output logic           busy
);

   localparam int              BEATS  = 128 / DW;
   localparam int              CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0]   C_LAST = CW'(BEATS - 1);

   generate
      if (DW != 8 && DW != 16 && DW != 32 && DW != 64 && DW != 128) begin : g_bad_dw
         $fatal(1, "aes_stream_if: DW must be 8, 16, 32, 64 or 128");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [127:0]     r_key, r_text, r_out;
   logic [CW-1:0]    r_key_cnt, r_text_cnt, r_out_cnt;
   logic             r_key_full, r_text_full, r_core_start, r_core_dec;

   logic             w_idle, w_key_rdy, w_text_rdy;
   logic             w_key_acc, w_text_acc, w_cmd_acc, w_done_acc, w_out_acc, w_out_last;
   logic [127+DW:0]  w_key_cat, w_text_cat, w_out_cat;

   assign w_idle     = (r_state == S_IDLE);
   assign w_key_rdy  = w_idle & ~flush;
   assign w_text_rdy = ~r_text_full & ~flush;
   assign din_ready  = din_key ? w_key_rdy : w_text_rdy;
   assign cmd_ready  = w_idle & r_key_full & r_text_full & ~flush;

   assign w_key_acc  = din_valid & din_key & w_key_rdy;
   assign w_text_acc = din_valid & ~din_key & w_text_rdy;
   assign w_cmd_acc  = cmd_valid & cmd_ready;
   assign w_done_acc = (r_state == S_RUN) & core_done & ~flush;
   assign w_out_acc  = (r_state == S_DRAIN) & dout_ready & ~flush;
   assign w_out_last = w_out_acc & (r_out_cnt == C_LAST);

   // Wide concatenations keep the shift legal for DW=128 as well.
   assign w_key_cat  = {din, r_key};
   assign w_text_cat = {din, r_text};
   assign w_out_cat  = {{DW{1'b0}}, r_out};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_cmd_acc)  w_state_nxt = S_RUN;
            S_RUN:   if (w_done_acc) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_out_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_key      <= '0;
         r_key_cnt  <= '0;
         r_key_full <= 1'b0;
      end else if (flush) begin
         r_key_cnt  <= '0;
         r_key_full <= 1'b0;
      end else if (w_key_acc) begin
         r_key <= w_key_cat[127+DW:DW];
         if (r_key_cnt == C_LAST) begin
            r_key_cnt  <= '0;
            r_key_full <= 1'b1;
         end else begin
            r_key_cnt <= r_key_cnt + 1'b1;
            if (r_key_cnt == '0) r_key_full <= 1'b0;
         end
      end
   end

   // text_full is 1 while core_start is high, so a text beat cannot coincide with the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_text      <= '0;
         r_text_cnt  <= '0;
         r_text_full <= 1'b0;
      end else if (flush) begin
         r_text_cnt  <= '0;
         r_text_full <= 1'b0;
      end else begin
         if (r_core_start) r_text_full <= 1'b0;
         if (w_text_acc) begin
            r_text <= w_text_cat[127+DW:DW];
            if (r_text_cnt == C_LAST) begin
               r_text_cnt  <= '0;
               r_text_full <= 1'b1;
            end else begin
               r_text_cnt <= r_text_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_core_start <= 1'b0;
         r_core_dec   <= 1'b0;
      end else begin
         r_core_start <= w_cmd_acc;
         if (w_cmd_acc) r_core_dec <= cmd_dec;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out     <= '0;
         r_out_cnt <= '0;
      end else if (flush) begin
         r_out_cnt <= '0;
      end else if (w_done_acc) begin
         r_out     <= core_result;
         r_out_cnt <= '0;
      end else if (w_out_acc) begin
         r_out     <= w_out_cat[127+DW:DW];
         r_out_cnt <= w_out_last ? '0 : r_out_cnt + 1'b1;
      end
   end

   assign core_key   = r_key;
   assign core_text  = r_text;
   assign core_start = r_core_start;
   assign core_dec   = r_core_dec;
   assign dout       = r_out[DW-1:0];
   assign dout_valid = (r_state == S_DRAIN);
   assign key_full   = r_key_full;
   assign text_full  = r_text_full;
   assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_aes_stream_if                                              |
// | Brief    : Directed self-checking bench for aes_stream_if (DW=8, DW=32).  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_aes_stream_if;

   localparam logic [127:0] C_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          flush8 = 0, din_valid8 = 0, din_key8 = 0, cmd_valid8 = 0, cmd_dec8 = 0;
   logic          dout_ready8 = 0, done8 = 0;
   logic [7:0]    din8 = '0;
   logic          din_ready8, cmd_ready8, start8, dec8, dout_valid8, key_full8, text_full8, busy8;
   logic [7:0]    dout8;
   logic [127:0]  key8, text8, result8 = '0;

   logic          flush32 = 0, din_valid32 = 0, din_key32 = 0, cmd_valid32 = 0, cmd_dec32 = 0;
   logic          dout_ready32 = 0, done32 = 0;
   logic [31:0]   din32 = '0;
   logic          din_ready32, cmd_ready32, start32, dec32, dout_valid32, key_full32, text_full32, busy32;
   logic [31:0]   dout32;
   logic [127:0]  key32, text32, result32 = '0;

   aes_stream_if #(.DW(8)) u_dut8 (
      .clk(clk), .rst(rst), .flush(flush8),
      .din(din8), .din_valid(din_valid8), .din_key(din_key8), .din_ready(din_ready8),
      .cmd_valid(cmd_valid8), .cmd_dec(cmd_dec8), .cmd_ready(cmd_ready8),
      .core_key(key8), .core_text(text8), .core_start(start8), .core_dec(dec8),
      .core_done(done8), .core_result(result8),
      .dout(dout8), .dout_valid(dout_valid8), .dout_ready(dout_ready8),
      .key_full(key_full8), .text_full(text_full8), .busy(busy8)
   );

   aes_stream_if #(.DW(32)) u_dut32 (
      .clk(clk), .rst(rst), .flush(flush32),
      .din(din32), .din_valid(din_valid32), .din_key(din_key32), .din_ready(din_ready32),
      .cmd_valid(cmd_valid32), .cmd_dec(cmd_dec32), .cmd_ready(cmd_ready32),
      .core_key(key32), .core_text(text32), .core_start(start32), .core_dec(dec32),
      .core_done(done32), .core_result(result32),
      .dout(dout32), .dout_valid(dout_valid32), .dout_ready(dout_ready32),
      .key_full(key_full32), .text_full(text_full32), .busy(busy32)
   );

   // Core models: done 11 cycles after start, fixed FIPS-197 vector as result.
   int cm8 = 0, cm32 = 0, n_start8 = 0;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         cm8 <= 0; done8 <= 1'b0;
      end else begin
         done8 <= 1'b0;
         if (start8) begin
            cm8      <= 10;
            n_start8 <= n_start8 + 1;
            result8  <= dec8 ? C_PT : C_CT;
         end else if (cm8 > 0) begin
            cm8 <= cm8 - 1;
            if (cm8 == 1) done8 <= 1'b1;
         end
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         cm32 <= 0; done32 <= 1'b0;
      end else begin
         done32 <= 1'b0;
         if (start32) begin
            cm32     <= 10;
            result32 <= dec32 ? C_PT : C_CT;
         end else if (cm32 > 0) begin
            cm32 <= cm32 - 1;
            if (cm32 == 1) done32 <= 1'b1;
         end
      end
   end

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic put8(input logic k, input logic [7:0] d);
      int n = 0;
      din8 = d; din_key8 = k; din_valid8 = 1'b1;
      #1;
      while (!din_ready8 && n < 50) begin @(negedge clk); #1; n++; end
      if (!din_ready8) check("din8_ready_timeout", 128'(din_ready8), 128'd1);
      @(negedge clk);
      din_valid8 = 1'b0;
   endtask

   task automatic load8(input logic k, input logic [127:0] v);
      for (int i = 0; i < 16; i++) put8(k, v[i*8 +: 8]);
   endtask

   task automatic cmd8(input logic dec);
      cmd_valid8 = 1'b1; cmd_dec8 = dec;
      #1;
      check("cmd8_ready", 128'(cmd_ready8), 128'd1);
      @(negedge clk);
      cmd_valid8 = 1'b0;
   endtask

   task automatic drain8(input logic [127:0] exp, input logic toggle, input int nbeats);
      int n = 0, beat = 0;
      logic ph = 1'b1, stalled = 1'b0;
      logic [7:0] held = '0;
      while (!dout_valid8 && n < 40) begin @(negedge clk); n++; end
      check("dout8_valid_wait", 128'(dout_valid8), 128'd1);
      n = 0;
      while (beat < nbeats && n < 100) begin
         if (stalled) begin
            check("dout8_hold", 128'(dout8), 128'(held));
            check("dout8_valid_hold", 128'(dout_valid8), 128'd1);
         end
         dout_ready8 = toggle ? ph : 1'b1;
         ph = ~ph;
         if (dout_ready8 && dout_valid8) begin
            check("dout8_beat", 128'(dout8), 128'(exp[beat*8 +: 8]));
            beat++;
            stalled = 1'b0;
         end else begin
            held = dout8;
            stalled = dout_valid8;
         end
         @(negedge clk);
         n++;
      end
      dout_ready8 = 1'b0;
      check("dout8_beats", 128'(beat), 128'(nbeats));
      if (nbeats == 16) begin
         check("dout8_valid_end", 128'(dout_valid8), 128'd0);
         check("busy8_end", 128'(busy8), 128'd0);
      end
   endtask

   task automatic put32(input logic k, input logic [31:0] d);
      int n = 0;
      din32 = d; din_key32 = k; din_valid32 = 1'b1;
      #1;
      while (!din_ready32 && n < 50) begin @(negedge clk); #1; n++; end
      if (!din_ready32) check("din32_ready_timeout", 128'(din_ready32), 128'd1);
      @(negedge clk);
      din_valid32 = 1'b0;
   endtask

   task automatic drain32(input logic [127:0] exp);
      int n = 0, beat = 0;
      while (!dout_valid32 && n < 40) begin @(negedge clk); n++; end
      check("dout32_valid_wait", 128'(dout_valid32), 128'd1);
      dout_ready32 = 1'b1;
      n = 0;
      while (beat < 4 && n < 20) begin
         if (dout_valid32) begin
            check("dout32_beat", 128'(dout32), 128'(exp[beat*32 +: 32]));
            beat++;
         end
         @(negedge clk);
         n++;
      end
      dout_ready32 = 1'b0;
      check("dout32_beats", 128'(beat), 128'd4);
      check("dout32_valid_end", 128'(dout_valid32), 128'd0);
      check("busy32_end", 128'(busy32), 128'd0);
   endtask

   logic seen_dv;

   initial begin
      repeat (2) @(negedge clk);
      check("rst_key", key8, 128'd0);
      check("rst_text", text8, 128'd0);
      check("rst_dout", 128'(dout8), 128'd0);
      check("rst_dout_valid", 128'(dout_valid8), 128'd0);
      check("rst_full", 128'({key_full8, text_full8}), 128'd0);
      check("rst_start_dec", 128'({start8, dec8}), 128'd0);
      check("rst_busy", 128'(busy8), 128'd0);
      check("rst_key32", key32, 128'd0);
      rst = 1'b1;
      @(negedge clk);

      // 1: load key and plaintext
      load8(1'b1, C_KEY);
      load8(1'b0, C_PT);
      check("t1_core_key", key8, C_KEY);
      check("t1_core_text", text8, C_PT);
      check("t1_full", 128'({key_full8, text_full8}), 128'd3);

      // 2: encrypt
      cmd8(1'b0);
      check("t2_start", 128'(start8), 128'd1);
      check("t2_dec", 128'(dec8), 128'd0);
      check("t2_text_full_hold", 128'(text_full8), 128'd1);
      din_valid8 = 1'b1; din_key8 = 1'b1; #1;
      check("t2_key_blocked", 128'(din_ready8), 128'd0);
      din_key8 = 1'b0; #1;
      check("t2_text_blocked", 128'(din_ready8), 128'd0);
      din_valid8 = 1'b0;
      @(negedge clk);
      check("t2_start_pulse", 128'(start8), 128'd0);
      check("t2_text_full_clr", 128'(text_full8), 128'd0);
      check("t2_busy", 128'(busy8), 128'd1);
      drain8(C_CT, 1'b0, 16);
      check("t2_start_count", 128'(n_start8), 128'd1);

      // 3: decrypt with last text beat colliding with the command, stalled sink
      for (int i = 0; i < 15; i++) put8(1'b0, C_CT[i*8 +: 8]);
      din8 = C_CT[127:120]; din_key8 = 1'b0; din_valid8 = 1'b1;
      cmd_valid8 = 1'b1; cmd_dec8 = 1'b1;
      #1;
      check("t3_cmd_blocked", 128'(cmd_ready8), 128'd0);
      check("t3_last_text_rdy", 128'(din_ready8), 128'd1);
      @(negedge clk);
      din_valid8 = 1'b0;
      #1;
      check("t3_cmd_ready", 128'(cmd_ready8), 128'd1);
      @(negedge clk);
      cmd_valid8 = 1'b0;
      check("t3_start", 128'(start8), 128'd1);
      check("t3_dec", 128'(dec8), 128'd1);
      drain8(C_PT, 1'b1, 16);

      // 4: reset in the middle of DRAIN
      load8(1'b0, C_PT);
      cmd8(1'b0);
      drain8(C_CT, 1'b0, 5);
      rst = 1'b0;
      #1;
      check("t4_key", key8, 128'd0);
      check("t4_text", text8, 128'd0);
      check("t4_dout", 128'(dout8), 128'd0);
      check("t4_flags", 128'({dout_valid8, busy8, key_full8, text_full8, start8}), 128'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      load8(1'b1, C_KEY);
      load8(1'b0, C_PT);
      cmd8(1'b0);
      drain8(C_CT, 1'b0, 16);

      // 5: flush during RUN, late core_done ignored
      load8(1'b0, C_PT);
      cmd8(1'b0);
      repeat (3) @(negedge clk);
      check("t5_busy_run", 128'(busy8), 128'd1);
      flush8 = 1'b1;
      #1;
      check("t5_flush_ready", 128'({din_ready8, cmd_ready8}), 128'd0);
      @(negedge clk);
      flush8 = 1'b0;
      seen_dv = 1'b0;
      for (int i = 0; i < 15; i++) begin
         seen_dv = seen_dv | dout_valid8 | busy8;
         @(negedge clk);
      end
      check("t5_no_output", 128'(seen_dv), 128'd0);
      check("t5_full_clr", 128'({key_full8, text_full8}), 128'd0);
      load8(1'b1, C_KEY);
      check("t5_core_key", key8, C_KEY);
      check("t5_key_full", 128'(key_full8), 128'd1);

      // 6: DW=32 encrypt
      for (int i = 0; i < 4; i++) put32(1'b1, C_KEY[i*32 +: 32]);
      for (int i = 0; i < 4; i++) put32(1'b0, C_PT[i*32 +: 32]);
      check("t6_core_key", key32, C_KEY);
      check("t6_core_text", text32, C_PT);
      check("t6_full", 128'({key_full32, text_full32}), 128'd3);
      cmd_valid32 = 1'b1; cmd_dec32 = 1'b0;
      #1;
      check("t6_cmd_ready", 128'(cmd_ready32), 128'd1);
      @(negedge clk);
      cmd_valid32 = 1'b0;
      check("t6_start", 128'(start32), 128'd1);
      drain32(C_CT);

      $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
